// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one synchronous single-port video RAM between VGA scan-out and a host port.
// Every clk cycle exactly one slot owner drives the RAM, in priority order:
//   DISP  (p_tick low, video_on high) -> framebuffer fetch for the current pixel block
//   WRITE (posted-write FIFO not empty) -> drain the FIFO head
//   READ  (FIFO empty, h_rd_req high, previous slot not READ) -> host read
//   IDLE  -> no strobe, address holds
// Ports:
//   clk, reset                 system clock (2x pixel rate), async active-high reset
//   p_tick, video_on           pixel enable and active-area flag from the sync generator
//   pixel_x, pixel_y           current scan position
//   ram_addr/ram_we/ram_wdata  RAM command; ram_rdata returns one cycle after the address
//   h_wr_valid/ready/addr/data posted host write port (valid/ready handshake)
//   h_rd_req/h_rd_addr         blocking host read request (level)
//   h_rd_valid/h_rd_data       one-cycle read response
//   rgb                        registered pixel output
module vram_arbiter #(
    parameter int unsigned AW       = 15,
    parameter int unsigned DW       = 8,
    parameter int unsigned FB_W     = 160,
    parameter int unsigned SCALE_SH = 2,
    parameter int unsigned FW       = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          h_wr_valid,
    output logic          h_wr_ready,
    input  logic [AW-1:0] h_wr_addr,
    input  logic [DW-1:0] h_wr_data,
    input  logic          h_rd_req,
    input  logic [AW-1:0] h_rd_addr,
    output logic          h_rd_valid,
    output logic [DW-1:0] h_rd_data,
    output logic [DW-1:0] rgb
);

    localparam int unsigned Depth = 1 << FW;
    // Product width: at least 17 bits so the full frame index never wraps before truncation.
    localparam int unsigned PW = (AW > 20) ? AW : 20;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotDisp,
        SlotWrite,
        SlotRead
    } slot_e;

    slot_e slot_d, slot_q;

    logic [AW-1:0] addr_q;
    logic          blank_q;
    logic [DW-1:0] rgb_d, rgb_q;
    logic [AW-1:0] disp_addr;

    logic [AW-1:0] fifo_addr_q [Depth];
    logic [DW-1:0] fifo_data_q [Depth];
    logic [FW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW:0]   count_q, count_d;
    logic          fifo_empty, fifo_full, push, pop;

    assign disp_addr = AW'(PW'(pixel_y >> SCALE_SH) * PW'(FB_W) + PW'(pixel_x >> SCALE_SH));

    // Write FIFO status; full blocks a push even when the same cycle pops.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FW+1)'(Depth));
    assign h_wr_ready = !fifo_full;
    assign push       = h_wr_valid && !fifo_full;
    assign pop        = (slot_d == SlotWrite);

    // Slot selection. Forced to IDLE while reset is asserted so the RAM sees no command.
    always_comb begin
        slot_d = SlotIdle;
        if (reset) begin
            slot_d = SlotIdle;
        end else if (!p_tick && video_on) begin
            slot_d = SlotDisp;
        end else if (!fifo_empty) begin
            slot_d = SlotWrite;
        end else if (h_rd_req && slot_q != SlotRead) begin
            // Back-to-back READ suppressed: a level request held into G+1 must not re-issue.
            slot_d = SlotRead;
        end
    end

    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        unique case (slot_d)
            SlotDisp:  ram_addr = disp_addr;
            SlotWrite: begin
                ram_addr  = fifo_addr_q[rd_ptr_q];
                ram_wdata = fifo_data_q[rd_ptr_q];
                ram_we    = 1'b1;
            end
            SlotRead:  ram_addr = h_rd_addr;
            default:   ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pixel register: load after a DISP slot, clear after a blanked fetch slot, else hold.
    always_comb begin
        rgb_d = rgb_q;
        if (slot_q == SlotDisp) begin
            rgb_d = ram_rdata;
        end else if (blank_q) begin
            rgb_d = '0;
        end
    end

    assign h_rd_valid = (slot_q == SlotRead);
    assign h_rd_data  = (slot_q == SlotRead) ? ram_rdata : '0;
    assign rgb        = rgb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q   <= SlotIdle;
            addr_q   <= '0;
            blank_q  <= 1'b0;
            rgb_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q  <= slot_d;
            blank_q <= !p_tick && !video_on;
            rgb_q   <= rgb_d;
            count_q <= count_d;
            if (slot_d != SlotIdle) begin
                addr_q <= ram_addr;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= h_wr_addr;
            fifo_data_q[wr_ptr_q] <= h_wr_data;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous RAM preloaded as addr[7:0].
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vram_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_tick, video_on;
    logic [9:0]    pixel_x, pixel_y;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          h_wr_valid, h_wr_ready;
    logic [AW-1:0] h_wr_addr;
    logic [DW-1:0] h_wr_data;
    logic          h_rd_req;
    logic [AW-1:0] h_rd_addr;
    logic          h_rd_valid;
    logic [DW-1:0] h_rd_data;
    logic [DW-1:0] rgb;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .FB_W    (160),
        .SCALE_SH(2),
        .FW      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .h_wr_valid(h_wr_valid),
        .h_wr_ready(h_wr_ready),
        .h_wr_addr (h_wr_addr),
        .h_wr_data (h_wr_data),
        .h_rd_req  (h_rd_req),
        .h_rd_addr (h_rd_addr),
        .h_rd_valid(h_rd_valid),
        .h_rd_data (h_rd_data),
        .rgb       (rgb)
    );

    // Synchronous single-port RAM, read-before-write.
    logic [7:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int cov [0:19199];

    initial begin
        int we_cnt, vl_cnt;
        int hc, vc, a, prev_kind, prev_addr, kind;
        int addr_bad, rgb_bad, disp_cnt, cov_bad;
        logic [7:0] exp_rgb;

        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 8'(i);

        // Reset: outputs idle even with a DISP condition and a push presented
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b1; pixel_x = 10'd8; pixel_y = 10'd4;
        h_wr_valid = 1'b1; h_wr_addr = 15'h55; h_wr_data = 8'hEE;
        h_rd_req = 1'b0; h_rd_addr = '0;
        repeat (3) @(posedge clk);
        mid();
        check_eq("rst_ready", 32'(h_wr_ready), 32'd1);
        check_eq("rst_we", 32'(ram_we), 32'd0);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_rd_valid", 32'(h_rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(h_rd_data), 32'd0);
        check_eq("rst_rgb", 32'(rgb), 32'd0);
        next_cycle();
        reset = 1'b0; h_wr_valid = 1'b0; video_on = 1'b0; p_tick = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (ram_we) we_cnt++;
            next_cycle();
            p_tick = ~p_tick;
        end
        check_eq("rst_push_dropped", 32'(we_cnt), 32'd0);
        check_eq("post_rst_ready", 32'(h_wr_ready), 32'd1);

        // Display fetch at (8,4) -> word 162, pixel lands two cycles later
        next_cycle(); video_on = 1'b1; p_tick = 1'b0; pixel_x = 10'd8; pixel_y = 10'd4;
        mid();
        check_eq("disp_addr", 32'(ram_addr), 32'd162);
        check_eq("disp_we", 32'(ram_we), 32'd0);
        next_cycle(); p_tick = 1'b1;
        mid();
        next_cycle(); p_tick = 1'b0; video_on = 1'b0;
        mid();
        check_eq("disp_rgb", 32'(rgb), 32'hA2);
        next_cycle(); p_tick = 1'b1;
        mid();
        check_eq("rgb_hold", 32'(rgb), 32'hA2);
        next_cycle(); p_tick = 1'b0;
        mid();
        check_eq("rgb_blank", 32'(rgb), 32'd0);

        // Blanking: 4 back-to-back writes drain on 4 consecutive cycles
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            p_tick = ~p_tick;
            h_wr_valid = (i < 4);
            h_wr_addr = 15'(16 + i);
            h_wr_data = 8'(8'hA0 + i);
            mid();
            if (i < 4) check_eq($sformatf("blank_ready%0d", i), 32'(h_wr_ready), 32'd1);
            check_eq($sformatf("blank_we%0d", i), 32'(ram_we), 32'((i >= 1) && (i <= 4)));
            if (i >= 1 && i <= 4) begin
                check_eq($sformatf("blank_addr%0d", i), 32'(ram_addr), 32'(16 + i - 1));
                check_eq($sformatf("blank_data%0d", i), 32'(ram_wdata), 32'(8'hA0 + i - 1));
            end
        end

        // Active video with the scan stalled on DISP: FIFO fills, then drains on p_tick=1 only
        video_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int idx;
            logic exp_we, exp_rdy;
            next_cycle();
            pixel_x = 10'd20; pixel_y = 10'd8;
            p_tick = (i >= 5) && (i % 2 == 1);
            idx = (i < 4) ? i : 4;
            h_wr_valid = (i <= 6);
            h_wr_addr = 15'(8'h30 + idx);
            h_wr_data = 8'(8'hC0 + idx);
            exp_we = (i >= 5) && (i % 2 == 1) && (i <= 13);
            exp_rdy = !(i == 4 || i == 5 || i == 7);
            mid();
            check_eq($sformatf("act_ready%0d", i), 32'(h_wr_ready), 32'(exp_rdy));
            check_eq($sformatf("act_we%0d", i), 32'(ram_we), 32'(exp_we));
            if (exp_we) begin
                check_eq($sformatf("act_addr%0d", i), 32'(ram_addr), 32'(8'h30 + (i - 5) / 2));
                check_eq($sformatf("act_data%0d", i), 32'(ram_wdata), 32'(8'hC0 + (i - 5) / 2));
            end else begin
                check_eq($sformatf("act_disp_addr%0d", i), 32'(ram_addr), 32'd325);
            end
        end

        // Write 0x5A to 100 then read 100: read waits for the drain
        next_cycle(); p_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        h_wr_valid = 1'b1; h_wr_addr = 15'd100; h_wr_data = 8'h5A;
        mid();
        check_eq("wr_rd_c0_we", 32'(ram_we), 32'd0);
        next_cycle(); p_tick = 1'b1; h_wr_valid = 1'b0; h_rd_req = 1'b1; h_rd_addr = 15'd100;
        mid();
        check_eq("wr_rd_c1_we", 32'(ram_we), 32'd1);
        check_eq("wr_rd_c1_addr", 32'(ram_addr), 32'd100);
        check_eq("wr_rd_c1_data", 32'(ram_wdata), 32'h5A);
        next_cycle(); p_tick = 1'b0;
        mid();
        check_eq("wr_rd_c2_valid", 32'(h_rd_valid), 32'd0);
        check_eq("wr_rd_c2_addr", 32'(ram_addr), 32'd0);
        next_cycle(); p_tick = 1'b1;
        mid();
        check_eq("wr_rd_c3_we", 32'(ram_we), 32'd0);
        check_eq("wr_rd_c3_addr", 32'(ram_addr), 32'd100);
        check_eq("wr_rd_c3_valid", 32'(h_rd_valid), 32'd0);
        next_cycle(); p_tick = 1'b0; h_rd_req = 1'b0;
        mid();
        check_eq("wr_rd_valid", 32'(h_rd_valid), 32'd1);
        check_eq("wr_rd_data", 32'(h_rd_data), 32'h5A);
        next_cycle(); p_tick = 1'b1;
        mid();
        check_eq("wr_rd_c5_valid", 32'(h_rd_valid), 32'd0);

        // Blanking reads: best-case latency, then a request held into G+2 re-issues
        next_cycle(); video_on = 1'b0; p_tick = 1'b0; h_rd_req = 1'b1; h_rd_addr = 15'h12;
        mid();
        check_eq("rd_bc_addr", 32'(ram_addr), 32'h12);
        check_eq("rd_bc_valid0", 32'(h_rd_valid), 32'd0);
        next_cycle(); p_tick = 1'b1;
        mid();
        check_eq("rd_bc_valid1", 32'(h_rd_valid), 32'd1);
        check_eq("rd_bc_data", 32'(h_rd_data), 32'hA2);
        next_cycle(); p_tick = 1'b0;
        mid();
        check_eq("rd_g2_valid", 32'(h_rd_valid), 32'd0);
        next_cycle(); p_tick = 1'b1; h_rd_req = 1'b0;
        mid();
        check_eq("rd_g3_valid", 32'(h_rd_valid), 32'd1);
        check_eq("rd_g3_data", 32'(h_rd_data), 32'hA2);
        next_cycle(); p_tick = 1'b0;
        mid();
        check_eq("rd_g4_valid", 32'(h_rd_valid), 32'd0);

        // Reset with a read granted: no response afterwards
        next_cycle(); p_tick = 1'b1; h_rd_req = 1'b1; h_rd_addr = 15'h13;
        mid();
        check_eq("rstA_granted", 32'(ram_addr), 32'h13);
        reset = 1'b1;
        vl_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            h_rd_req = 1'b0;
            if (i == 1) reset = 1'b0;
            p_tick = ~p_tick;
            mid();
            if (h_rd_valid) vl_cnt++;
            if (ram_we) we_cnt++;
        end
        check_eq("rstA_no_valid", 32'(vl_cnt), 32'd0);
        check_eq("rstA_no_we", 32'(we_cnt), 32'd0);

        // Reset with 3 writes queued and a read pending
        video_on = 1'b1; pixel_x = 10'd8; pixel_y = 10'd4;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            p_tick = 1'b0;
            h_wr_valid = (i < 3);
            h_wr_addr = 15'(8'h40 + i);
            h_wr_data = 8'h11;
            h_rd_req = (i == 3);
            h_rd_addr = 15'h40;
            mid();
        end
        check_eq("rstB_pre_rgb", 32'(rgb), 32'hA2);
        check_eq("rstB_pre_ready", 32'(h_wr_ready), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rstB_rgb", 32'(rgb), 32'd0);
        check_eq("rstB_ready", 32'(h_wr_ready), 32'd1);
        check_eq("rstB_we", 32'(ram_we), 32'd0);
        check_eq("rstB_addr", 32'(ram_addr), 32'd0);
        vl_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 1) reset = 1'b0;
            video_on = 1'b0; p_tick = ~p_tick; h_wr_valid = 1'b0; h_rd_req = 1'b0;
            mid();
            if (h_rd_valid) vl_cnt++;
            if (ram_we) we_cnt++;
            if (i == 1) check_eq("rstB_post_addr", 32'(ram_addr), 32'd0);
        end
        check_eq("rstB_no_valid", 32'(vl_cnt), 32'd0);
        check_eq("rstB_no_we", 32'(we_cnt), 32'd0);
        check_eq("rstB_post_ready", 32'(h_wr_ready), 32'd1);
        check_eq("rstB_post_rgb", 32'(rgb), 32'd0);
        check_eq("rstB_ram40", 32'(ram_mem[15'h40]), 32'h40);

        // Scan of the last block row (lines 476..479) plus the start of vertical blanking
        addr_bad = 0; rgb_bad = 0; disp_cnt = 0; cov_bad = 0;
        prev_kind = 0; prev_addr = 0; exp_rgb = '0;
        for (int n = 0; n < 4 * 1600 + 40; n++) begin
            next_cycle();
            hc = (n / 2) % 800;
            vc = 476 + (n / 2) / 800;
            p_tick = (n % 2 == 1);
            pixel_x = 10'(hc);
            pixel_y = 10'(vc);
            video_on = (hc < 640) && (vc < 480);
            mid();
            if (n >= 2 && rgb !== exp_rgb) rgb_bad++;
            if (ram_we) addr_bad++;
            kind = 0;
            a = (vc / 4) * 160 + hc / 4;
            if (!p_tick && video_on) begin
                kind = 1;
                disp_cnt++;
                if (32'(ram_addr) != a) addr_bad++;
                if (int'(ram_addr) < 19200) cov[ram_addr]++;
            end else if (!p_tick) begin
                kind = 2;
            end
            if (prev_kind == 1) exp_rgb = 8'(prev_addr);
            else if (prev_kind == 2) exp_rgb = '0;
            prev_kind = kind;
            prev_addr = a;
        end
        for (int i = 19040; i < 19200; i++) if (cov[i] != 16) cov_bad++;
        check_eq("scan_addr", 32'(addr_bad), 32'd0);
        check_eq("scan_rgb", 32'(rgb_bad), 32'd0);
        check_eq("scan_disp_count", 32'(disp_cnt), 32'd2560);
        check_eq("scan_coverage", 32'(cov_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one synchronous single-port video RAM between VGA scan-out and a host port. It sits between the 640x480 sync generator and the framebuffer RAM. It uses the sync generator's `p_tick`, `video_on` and `pixel_x`/`pixel_y` to reserve RAM slots for display fetch. Host writes are buffered in a small posted-write FIFO and drained into free slots; host reads are blocking.

## Interface
Parameters:
- `AW`, default 15: RAM address width.
- `DW`, default 8: RAM data / pixel width.
- `FB_W`, default 160: framebuffer width in words.
- `SCALE_SH`, default 2: pixel-to-word shift. Each word is shown as a 4x4 pixel block.
- `FW`, default 2: log2 of write-FIFO depth, giving 4 entries.

Ports:
- `clk`  in  1  system clock (2x pixel rate).
- `reset`  in  1  asynchronous, active-high.
- `p_tick`  in  1  pixel enable, high every other `clk`.
- `video_on`  in  1  active-area flag.
- `pixel_x`, `pixel_y`  in  10 each  current scan position.
- `ram_addr`  out  AW  RAM address.
- `ram_we`  out  1  RAM write strobe.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data, valid the cycle after the address.
- `h_wr_valid`  in  1  host write request.
- `h_wr_ready`  out  1  host write accepted when valid and ready are both high.
- `h_wr_addr`  in  AW  host write address.
- `h_wr_data`  in  DW  host write data.
- `h_rd_req`  in  1  host read request, level.
- `h_rd_addr`  in  AW  host read address.
- `h_rd_valid`  out  1  one-cycle pulse carrying read data.
- `h_rd_data`  out  DW  host read data.
- `rgb`  out  DW  registered pixel output.

## Operation
- Each `clk` cycle, exactly one slot owner is chosen for the RAM, in strict priority order:
  - DISP: when `p_tick`==0 and `video_on`==1. `ram_addr` = (`pixel_y`>>`SCALE_SH`)*`FB_W` + (`pixel_x`>>`SCALE_SH`), truncated to AW bits; `ram_we`=0.
  - WRITE: when the slot is not DISP and the FIFO is not empty. Pop the head and drive its address and data with `ram_we`=1.
  - READ: when the slot is neither DISP nor WRITE, the FIFO is empty, `h_rd_req`=1, and the previous cycle was not READ. Drive `h_rd_addr` with `ram_we`=0.
  - IDLE: otherwise. `ram_we`=0 and `ram_addr` holds its last value.
- Write FIFO:
  - Depth 2**`FW`; `h_wr_ready` = not full.
  - A push while full is impossible, even in a cycle that also pops.
  - Push and pop in the same cycle leave the count unchanged.
  - Order is preserved, and writes are applied to RAM in acceptance order.
- Read ordering: a host read is never issued while any posted write is pending, so reads always observe prior writes.
- Host read handshake:
  - After a READ slot in cycle G, `h_rd_valid`=1 and `h_rd_data`=`ram_rdata` in cycle G+1.
  - The host must hold `h_rd_addr` stable while `h_rd_req` is high and drop `h_rd_req` in cycle G+1. A request still high in G+2 is treated as a new read.
- `rgb` update:
  - Registered at the end of every cycle following a DISP slot: `rgb` <= `ram_rdata`.
  - At the end of every cycle following a `p_tick`==0 cycle with `video_on`==0: `rgb` <= 0.
  - Otherwise `rgb` holds.
- Reset, while asserted and after release:
  - FIFO pointers and count are 0, so `h_wr_ready`=1.
  - `ram_we`=0, `ram_addr`=0, `h_rd_valid`=0, `h_rd_data`=0, `rgb`=0.
  - Pushes presented during reset are discarded.
  - Reset mid-operation drops FIFO contents and any read in flight; no `h_rd_valid` pulse follows.

## Timing
- Display read latency: address issued in the `p_tick`=0 cycle, data arrives in the `p_tick`=1 cycle, and `rgb` is valid from the next edge. `rgb` therefore lags `pixel_x` by one pixel period (2 `clk`). The display pipeline compensates externally.
- Host write bandwidth:
  - During active video, one drain per 2 cycles (the `p_tick`=1 slots).
  - During blanking, one per cycle.
- Host read latency:
  - Best case, 1 cycle from `h_rd_req` high with an empty FIFO to `h_rd_valid`.
  - Worst case in active video, FIFO depth*2 + 2 cycles.
- Address arithmetic:
  - The full product is computed at least 17 bits wide, then truncated.
  - Maximum in-range value: 119*160+159 = 19199 (0x4AFF).

## Test plan
- Reset, then hold `video_on`=1 with the RAM preloaded as addr[7:0]. At `pixel_x`=8, `pixel_y`=4, `ram_addr`=162 in the `p_tick`=0 cycle; `rgb`=0xA2 two cycles later.
- Blanking: 4 back-to-back host writes at `video_on`=0 are accepted with `h_wr_ready`=1 throughout. `ram_we` pulses on 4 consecutive cycles with the same addresses and data in order.
- Active video: 5 writes presented back-to-back. `h_wr_ready` drops after the 4th until the first pop; RAM writes occur only on `p_tick`=1 cycles, and no DISP slot is ever displaced.
- Write 0x5A to addr 100, then immediately read addr 100. The read is issued only after the write drains, and `h_rd_valid`=1 with `h_rd_data`=0x5A.
- Assert reset with 3 writes queued and a read granted. No `ram_we` and no `h_rd_valid` occur afterwards; `h_wr_ready`=1 and `rgb`=0.
- Full frame at 800x525: `rgb` is 0 whenever the delayed `video_on` is 0, and the scan-out addresses cover 0..19199, each exactly 16 times per frame.
